vga_timing_gen: RTL

//  Source end of vga_if: produces the raster timing (hcount/vcount, syncs, blanks) that every draw stage consumes.

---
 rtl/vga_timing_pkg.sv | 46 ++++
 rtl/vga_if.sv | 15 +
 rtl/vga_axis_counter.sv | 51 +++++
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Package: vga_timing_pkg
// Default 800x600@60 raster timing (40 MHz pixel clock), the derived line/frame
// totals and sync/blank boundaries, the raster counter width, and the colour
// table used by the optional test-bar pattern.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 23;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Blank starts at the first non-visible count; sync covers [START, STOP).
  localparam int H_BLNK_START_DEF = H_ACTIVE_DEF;
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_STOP_DEF  = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_BLNK_START_DEF = V_ACTIVE_DEF;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_STOP_DEF  = V_SYNC_START_DEF + V_SYNC_DEF;

  // Eight-bar colour table, brightest on the left, black on the right.
  function automatic logic [11:0] bar_colour(input logic [CNT_W-1:0] idx);
    logic [11:0] c;
    case (idx)
      11'd0:   c = 12'hFFF;  // white
      11'd1:   c = 12'hFF0;  // yellow
      11'd2:   c = 12'h0FF;  // cyan
      11'd3:   c = 12'h0F0;  // green
      11'd4:   c = 12'hF0F;  // magenta
      11'd5:   c = 12'hF00;  // red
      11'd6:   c = 12'h00F;  // blue
      11'd7:   c = 12'h000;  // black
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Interface: vga_if
// Raster bus shared by the draw pipeline: counts, syncs, blanks and pixel colour.
// Modport out is the producing end (timing generator), modport in is a consumer.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/vga_axis_counter.sv
// Module: vga_axis_counter
// Wrap counter for one raster axis, counting 0..TOTAL-1.
// Ports: clk, rst (sync, active-high), inc (advance by one this edge),
//        cnt_nxt (value the counter takes on the coming edge, so callers can
//        decode it into registers that line up with the count), wrap (this
//        edge takes the counter from TOTAL-1 back to 0).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = H_TOTAL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reset wins, then advance with wrap at TOTAL-1.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (rst) begin
      cnt_d = ZERO;
    end else if (inc) begin
      if (cnt_q == LAST) begin
        cnt_d = ZERO;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign cnt_nxt = cnt_d;

  // Count register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Module: vga_timing_gen
// Head of the pixel pipeline: generates raster timing on vga_if and a per-frame
// tick plus frame counter for animation pacing.
// Ports: clk (pixel clock), rst (sync, active-high),
//        out (vga_if.out: hcount, vcount, hsync, hblnk, vsync, vblnk, rgb),
//        frame_start (one-cycle pulse when (0,0) follows a frame wrap),
//        frame_cnt (frames completed since reset, wraps at 16 bits).
// Build option: define VGA_TEST_PATTERN_EN to drive eight vertical colour bars
// in the visible area; otherwise rgb is held at 0.
// Every output is registered and decoded from the counters' next values, so
// sync/blank/rgb always describe the hcount/vcount shown on the same cycle.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.out          out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_BLNK_START = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_STOP  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_BLNK_START = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_STOP  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_width_chk
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
  end

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             v_wrap;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (1'b1),
    .cnt_nxt (h_nxt),
    .wrap    (h_wrap)
  );

  // The vertical axis only steps on the horizontal wrap, so vertical decodes
  // can only change on the line-wrap edge.
  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (h_wrap),
    .cnt_nxt (v_nxt),
    .wrap    (v_wrap)
  );

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vsync_q, vsync_d;
  logic             vblnk_q, vblnk_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  // Timing decode from the next counts; the frame tick fires only on the
  // full-frame wrap, so the (0,0) held during reset never pulses.
  always_comb begin
    hcount_d      = h_nxt;
    vcount_d      = v_nxt;
    hsync_d       = 1'b0;
    hblnk_d       = 1'b0;
    vsync_d       = 1'b0;
    vblnk_d       = 1'b0;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    if (rst) begin
      frame_cnt_d = 16'h0000;
    end else begin
      hblnk_d       = (h_nxt >= H_BLNK_START);
      hsync_d       = (h_nxt >= H_SYNC_START) && (h_nxt < H_SYNC_STOP);
      vblnk_d       = (v_nxt >= V_BLNK_START);
      vsync_d       = (v_nxt >= V_SYNC_START) && (v_nxt < V_SYNC_STOP);
      frame_start_d = h_wrap && v_wrap;
      frame_cnt_d   = frame_cnt_q + {15'd0, frame_start_d};
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

  // Colour bars in the visible area, black in blanking and in reset.
  always_comb begin
    rgb_d = 12'h000;
    if (!rst && !hblnk_d && !vblnk_d) begin
      rgb_d = bar_colour(h_nxt / BAR_W);
    end else begin
      rgb_d = 12'h000;
    end
  end
`else
  assign rgb_d = 12'h000;
`endif

  // Output registers.
  always_ff @(posedge clk) begin
    hcount_q      <= hcount_d;
    vcount_q      <= vcount_d;
    hsync_q       <= hsync_d;
    hblnk_q       <= hblnk_d;
    vsync_q       <= vsync_d;
    vblnk_q       <= vblnk_d;
    rgb_q         <= rgb_d;
    frame_start_q <= frame_start_d;
    frame_cnt_q   <= frame_cnt_d;
  end

  assign out.hcount  = hcount_q;
  assign out.vcount  = vcount_q;
  assign out.hsync   = hsync_q;
  assign out.hblnk   = hblnk_q;
  assign out.vsync   = vsync_q;
  assign out.vblnk   = vblnk_q;
  assign out.rgb     = rgb_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
